// File: rtl/decode_fifo_pkg.sv
// Shared definitions for the decode buffer: default micro-instruction width and depth.
package decode_fifo_pkg;

  localparam int unsigned DecodeInfoDw = 32;
  localparam int unsigned DecodeFifoAw = 2;

endpackage

// File: rtl/gen_fifo.sv
// Generic synchronous FIFO: wrap-bit pointers, combinational head read, flush to empty.
module gen_fifo #(
  parameter int unsigned Width          = 8,
  parameter int unsigned AddrW          = 2,
  parameter bit          ProtocolChecks = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AddrW:0]   count_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wptr_en, rptr_en;
  logic             push_en, pop_en;
  logic [Width-1:0] mem_q [Depth];

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) && (wptr_q[AddrW] != rptr_q[AddrW]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  always_comb begin
    push_en = push_i & ~full_o & ~flush_i;
    pop_en  = pop_i & ~empty_o & ~flush_i;
    wptr_en = push_en;
    wptr_d  = wptr_q + 1'b1;
    // Flush collapses the queue by catching the read pointer up to the write pointer.
    rptr_en = pop_en | flush_i;
    rptr_d  = flush_i ? wptr_q : rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wptr_en) wptr_q <= wptr_d;
      if (rptr_en) rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

  if (ProtocolChecks) begin : g_checks
    push_while_full_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && full_o && !flush_i));
    pop_while_empty_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(pop_i && empty_o && !flush_i));
  end

endmodule

// File: rtl/decode_fifo.sv
// Decoder-to-dispatch buffer; wraps gen_fifo with pipeline port names.
module decode_fifo
  import decode_fifo_pkg::*;
#(
  parameter int unsigned DW             = DecodeInfoDw,
  parameter int unsigned AW             = DecodeFifoAw,
  parameter bit          ProtocolChecks = 1'b1
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          instrFifo_push,
  input  logic [DW-1:0] decode_microInstr,
  output logic          instrFifo_reject,
  input  logic          dispatch_pop,
  output logic [DW-1:0] dispatch_microInstr,
  output logic          instrFifo_empty,
  output logic [AW:0]   instrFifo_count,
  input  logic          flush
);

  gen_fifo #(
    .Width          (DW),
    .AddrW          (AW),
    .ProtocolChecks (ProtocolChecks)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTn),
    .push_i  (instrFifo_push),
    .wdata_i (decode_microInstr),
    .pop_i   (dispatch_pop),
    .flush_i (flush),
    .rdata_o (dispatch_microInstr),
    .empty_o (instrFifo_empty),
    .full_o  (instrFifo_reject),
    .count_o (instrFifo_count)
  );

endmodule

// File: tb/tb_decode_fifo.sv
// Randomized and directed bench for decode_fifo against a queue-based reference.
module tb_decode_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 2;
  localparam int unsigned Depth = 2 ** AW;

  logic          clk;
  logic          rst_n;
  logic          push;
  logic [DW-1:0] din;
  logic          reject;
  logic          pop;
  logic [DW-1:0] dout;
  logic          empty;
  logic [AW:0]   count;
  logic          flush_in;

  int unsigned n_vec;
  int unsigned n_err;
  logic [DW-1:0] model_q [$];

  decode_fifo #(
    .DW             (DW),
    .AW             (AW),
    .ProtocolChecks (1'b0)
  ) dut (
    .CLK                 (clk),
    .RSTn                (rst_n),
    .instrFifo_push      (push),
    .decode_microInstr   (din),
    .instrFifo_reject    (reject),
    .dispatch_pop        (pop),
    .dispatch_microInstr (dout),
    .instrFifo_empty     (empty),
    .instrFifo_count     (count),
    .flush               (flush_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".reject"}, 32'(reject), 32'(model_q.size() == Depth));
    check({tag, ".excl"}, 32'(empty & reject), 32'd0);
    if (model_q.size() > 0) check({tag, ".head"}, dout, model_q[0]);
  endtask

  // One clock: apply inputs, update the reference from pre-edge occupancy, then check.
  task automatic cyc(input string tag, input bit p, input logic [DW-1:0] d, input bit q,
                     input bit f);
    bit do_pop, do_push;
    push = p; din = d; pop = q; flush_in = f;
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      do_pop  = q && (model_q.size() > 0);
      do_push = p && (model_q.size() < Depth);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    #1;
    push = 1'b0; pop = 1'b0; flush_in = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_q.delete();
    check_state("reset");
  endtask

  initial begin
    logic [DW-1:0] v;
    n_vec = 0; n_err = 0;
    push = 1'b0; pop = 1'b0; flush_in = 1'b0; din = '0; rst_n = 1'b0;
    @(negedge clk);
    do_reset(2);
    cyc("idle", 1'b0, '0, 1'b0, 1'b0);

    // Fill to full, then an ignored fifth push.
    cyc("fill", 1'b1, 32'h11, 1'b0, 1'b0);
    cyc("fill", 1'b1, 32'h22, 1'b0, 1'b0);
    cyc("fill", 1'b1, 32'h33, 1'b0, 1'b0);
    cyc("fill", 1'b1, 32'h44, 1'b0, 1'b0);
    check("full_reject", 32'(reject), 32'd1);
    cyc("over", 1'b1, 32'h55, 1'b0, 1'b0);
    check("over_count", 32'(count), 32'd4);

    // Drain in order; head checked before each pop.
    for (int i = 0; i < 4; i++) begin
      check("drain_data", dout, 32'h11 * (i + 1));
      cyc("drain", 1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    cyc("under", 1'b0, '0, 1'b1, 1'b0);
    check("under_count", 32'(count), 32'd0);

    // Steady-state push+pop at occupancy 2.
    cyc("pre2", 1'b1, 32'hA0, 1'b0, 1'b0);
    cyc("pre2", 1'b1, 32'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc("pp", 1'b1, 32'hB0 + i, 1'b1, 1'b0);
      check("pp_count", 32'(count), 32'd2);
    end

    // Push+pop at full: only the pop applies.
    cyc("tofull", 1'b1, 32'hC0, 1'b0, 1'b0);
    cyc("tofull", 1'b1, 32'hC1, 1'b0, 1'b0);
    cyc("fullpp", 1'b1, 32'h66, 1'b1, 1'b0);
    check("fullpp_count", 32'(count), 32'd3);
    check("fullpp_reject", 32'(reject), 32'd0);

    // Flush beats push and pop.
    cyc("flush", 1'b1, 32'h99, 1'b1, 1'b1);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_count", 32'(count), 32'd0);
    cyc("post_flush", 1'b1, 32'h77, 1'b0, 1'b0);
    check("post_flush_head", dout, 32'h77);
    check("post_flush_empty", 32'(empty), 32'd0);

    // Random traffic across many pointer wraps, with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      v = $urandom;
      cyc("rand", ($urandom_range(0, 3) != 0), v, ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 40) == 0));
    end

    // Reset in the middle of traffic overrides everything.
    cyc("pre_rst", 1'b1, 32'hDD, 1'b0, 1'b0);
    push = 1'b1; pop = 1'b1; flush_in = 1'b1; din = 32'hEE;
    do_reset(1);
    push = 1'b0; pop = 1'b0; flush_in = 1'b0;
    cyc("post_rst", 1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_fifo.md
Name: decode_fifo

Overview:
- Decoupling buffer between the front-end decoder and the dispatch stage.
- Accepts one decoded micro-instruction per cycle from the decoder (push/reject handshake).
- Presents the oldest entry to dispatch (pop/empty handshake).
- Discards all contents on pipeline flush, so no wrong-path instruction reaches dispatch after a mispredict or privileged redirect.

Parameters:
- DW, `DECODE_INFO_DW, width of one decoded micro-instruction
- AW, 2, log2 of depth; depth = 2**AW entries (4 by default, power of two only)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RSTn  input  1  synchronous reset, active low
- instrFifo_push  input  1  decoder writes decode_microInstr this cycle
- decode_microInstr  input  DW  micro-instruction from decoder
- instrFifo_reject  output  1  FIFO full; decoder must hold its instruction
- dispatch_pop  input  1  dispatch consumes head entry this cycle
- dispatch_microInstr  output  DW  head entry (valid only when instrFifo_empty=0)
- instrFifo_empty  output  1  no entry available
- instrFifo_count  output  AW+1  current occupancy, 0..2**AW
- flush  input  1  discard all entries (mispredict or privileged redirect)

Behaviour:
- State:
  - Storage array of 2**AW x DW.
  - Read and write pointers, each AW+1 bits; the extra MSB is the wrap bit.
  - No FSM beyond the pointers.
- Reset: on a rising CLK edge with RSTn=0, both pointers are cleared to 0. Consequently:
  - instrFifo_empty=1
  - instrFifo_reject=0
  - instrFifo_count=0
  - Storage contents are don't-care; dispatch_microInstr is undefined while empty.
- Status flags, combinational from the pointers only (no input-to-output path):
  - empty = (wptr == rptr)
  - full = (wptr[AW-1:0] == rptr[AW-1:0]) and (wptr[AW] != rptr[AW])
  - instrFifo_reject = full
  - instrFifo_count = wptr - rptr, modulo 2**(AW+1)
- Push:
  - Effective when instrFifo_push=1, full=0 and flush=0.
  - Writes mem[wptr[AW-1:0]], then wptr increments.
  - A push while full is ignored: no write, no pointer change. This is a decoder protocol violation; flag it with an assertion.
- Pop:
  - Effective when dispatch_pop=1, empty=0 and flush=0; rptr increments.
  - A pop while empty is ignored (assertion).
- Read data: dispatch_microInstr = mem[rptr[AW-1:0]], a combinational read of the head.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no write-to-read bypass when empty.
- Simultaneous push and pop:
  - Not empty, not full: both take effect and count is unchanged.
  - Full: only the pop takes effect; reject stays asserted that cycle and the decoder retries next cycle.
  - Empty: only the push takes effect.
- Flush:
  - Highest priority. Sets rptr <= wptr, so count becomes 0 next cycle.
  - Any push or pop in the same cycle is discarded.
  - Storage is not cleared.
- Wrap-around: pointers wrap naturally at 2**(AW+1). Full and empty remain distinguishable via the wrap bit.
- Reset mid-operation: reset overrides flush, push and pop, and returns the block to its post-reset state in one cycle.
- Pointer updates use the gated enable style (gen_dffr with enable); storage uses gen_dffren per entry, with no reset on data.

Decomposition:
- Shared definitions in define.vh:
  - `DECODE_INFO_DW, already present.
  - Add `DECODE_FIFO_AW as the default for AW.
- The natural sub-module is gen_fifo: a generic, width- and depth-parameterised synchronous FIFO carrying only the pointer, flag and storage logic.
- decode_fifo wraps gen_fifo, mapping push/pop/flush and naming the ports for the pipeline.
- gen_fifo is reusable later for the issue and commit queues.

Test Plan:
- Reset then idle: RSTn low 2 cycles, then high -> instrFifo_empty=1, instrFifo_reject=0, instrFifo_count=0.
- Fill to full: push 0x11,0x22,0x33,0x44 on consecutive cycles with no pop -> count 1,2,3,4; reject=1 after the 4th push; a 5th push of 0x55 is ignored, count stays 4.
- Drain in order: from full, pop 4 cycles -> dispatch_microInstr reads 0x11,0x22,0x33,0x44; empty=1 after the 4th pop; a further pop leaves count at 0.
- Simultaneous push and pop:
  - count=2, push and pop for 10 cycles -> count stays 2 and data emerges in push order.
  - At full, push 0x66 with pop -> only the pop is applied, count=3, reject=0 next cycle.
- Flush priority: count=3, flush=1 together with push and pop -> next cycle empty=1, count=0; a subsequent push of 0x77 appears at the head one cycle later.
- Wrap-around: push/pop 2**(AW+1)+3 entries with random pop gaps -> scoreboard order matches, empty and full are never asserted together, count always equals the scoreboard depth.
